smg_scan_ctrl: RTL

//   Parametrised 7-segment digit scanner with segment multiplexing for the AX309 display chain.

---
 rtl/smg_scan_if.sv | 27 ++
 rtl/smg_scan_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/smg_scan_if.sv
// smg_scan_if: encoder-side inputs and pin-side outputs
// of the multiplexed 7-segment scanner.
interface smg_scan_if #(
    parameter int N_DIGITS = 6,
    parameter int SEG_W    = 8
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                      en;
    logic [N_DIGITS-1:0]       digit_mask;
    logic [3:0]                brightness;
    logic [N_DIGITS*SEG_W-1:0] seg_data_in;
    logic [N_DIGITS-1:0]       scan_sig;
    logic [SEG_W-1:0]          seg_out;
    logic [IDX_W-1:0]          digit_idx;
    logic                      frame_tick;

    modport master (
        output en, digit_mask, brightness, seg_data_in,
        input  scan_sig, seg_out, digit_idx, frame_tick
    );

    modport slave (
        input  en, digit_mask, brightness, seg_data_in,
        output scan_sig, seg_out, digit_idx, frame_tick
    );
endinterface

// File: rtl/smg_scan_ctrl.sv
// smg_scan_ctrl: 7-segment digit scanner with anti-ghost blanking,
// digit skip mask, 16-step PWM brightness and a frame pulse.
module smg_scan_ctrl #(
    parameter int N_DIGITS    = 6,
    parameter int SEG_W       = 8,
    parameter int SCAN_TICKS  = 50000,
    parameter int BLANK_TICKS = 500,
    parameter int CNT_W       = 16
) (
    input  logic      CLK,
    input  logic      RST,
    smg_scan_if.slave bus
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0] SC_ON   = CNT_W'(BLANK_TICKS);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, ON} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    sc_q, sc_d;
    logic [N_DIGITS-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_DIGITS-1:0] scan_q, scan_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic                tick_q, tick_d;
    logic [SEG_W-1:0]    seg_arr [N_DIGITS];
    logic [3:0]          pwm_p;
    logic                lit;

    function automatic logic [IDX_W-1:0] hi_idx(
        input logic [N_DIGITS-1:0] m
    );
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (m[i]) r = IDX_W'(i);
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] lo_idx(
        input logic [N_DIGITS-1:0] m
    );
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--)
            if (m[i]) r = IDX_W'(i);
        return r;
    endfunction

    // Walk downward from cur with wrap; the nearest enabled digit wins.
    function automatic logic [IDX_W-1:0] nxt_idx(
        input logic [N_DIGITS-1:0] m,
        input logic [IDX_W-1:0]    cur
    );
        logic [IDX_W-1:0] r;
        int j;
        r = cur;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            j = int'(cur) + N_DIGITS - k;
            if (j >= N_DIGITS) j -= N_DIGITS;
            if (m[j]) r = IDX_W'(j);
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < N_DIGITS; i++)
            seg_arr[i] = bus.seg_data_in[i*SEG_W +: SEG_W];
    end

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        seg_d   = seg_q;
        case (state_q)
            IDLE: begin
                sc_d  = '0;
                seg_d = '1;
                if (bus.en && |bus.digit_mask) begin
                    state_d = BLANK;
                    mask_d  = bus.digit_mask;
                    idx_d   = hi_idx(bus.digit_mask);
                    seg_d   = seg_arr[idx_d];
                end
            end
            default: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    sc_d    = '0;
                    seg_d   = '1;
                end else if (sc_q == SC_LAST) begin
                    // Slot start: mask and pattern are latched only here.
                    if (|bus.digit_mask) begin
                        state_d = BLANK;
                        sc_d    = '0;
                        mask_d  = bus.digit_mask;
                        idx_d   = nxt_idx(bus.digit_mask, idx_q);
                        seg_d   = seg_arr[idx_d];
                    end else begin
                        state_d = IDLE;
                        sc_d    = '0;
                        seg_d   = '1;
                    end
                end else begin
                    sc_d    = sc_q + CNT_W'(1);
                    state_d = (sc_d >= SC_ON) ? ON : BLANK;
                end
            end
        endcase

        pwm_p  = sc_d[3:0] - SC_ON[3:0];
        lit    = (bus.brightness == 4'hF) || (pwm_p < bus.brightness);
        scan_d = '1;
        if (state_d == ON && lit)
            scan_d = ~(N_DIGITS'(1) << idx_d);
        tick_d = (state_d != IDLE) && (sc_d == SC_LAST)
                 && (idx_d == lo_idx(mask_d));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sc_q    <= '0;
            mask_q  <= '0;
            idx_q   <= IDX_TOP;
            scan_q  <= '1;
            seg_q   <= '1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            scan_q  <= scan_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.scan_sig   = scan_q;
    assign bus.seg_out    = seg_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_tick = tick_q;
endmodule
